// File: rtl/instr_fetch_buffer.sv
// Instruction-fetch buffer: issues one read at a time to a variable-latency
// instruction memory and queues each returned word with its PC.
// Decode pulls the queued entries through a valid/ready handshake.
// A flush discards everything buffered or still in flight.
module instr_fetch_buffer #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PCIn,
    output logic              PCStall,
    input  logic              Flush,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemData,
    output logic              InstrValid,
    input  logic              InstrReady,
    output logic [DATA_W-1:0] Instruction,
    output logic [ADDR_W-1:0] InstrPC,
    output logic [ADDR_W-1:0] InstrPCPlus4
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [ADDR_W-1:0] r_req_addr;

    logic [DATA_W-1:0] r_instr_mem [DEPTH];
    logic [ADDR_W-1:0] r_pc_mem    [DEPTH];

    logic w_issue;
    logic w_push;
    logic w_pop;

    // Issue only when a slot is guaranteed free for the reply; Reset gates
    // the request so nothing escapes while the block is held in reset.
    assign w_issue = (r_state == S_IDLE) && (r_count < CNT_W'(DEPTH)) && !Flush && !Reset;
    assign w_push  = (r_state == S_WAIT) && MemAck && !Flush;
    assign w_pop   = InstrValid && InstrReady && !Flush;

    assign MemReq       = w_issue;
    assign MemAddr      = PCIn;
    assign PCStall      = !w_issue;
    assign InstrValid   = (r_count != '0);
    assign Instruction  = r_instr_mem[r_head];
    assign InstrPC      = r_pc_mem[r_head];
    assign InstrPCPlus4 = r_pc_mem[r_head] + ADDR_W'(4);

    // Request FSM: one outstanding read; a flush while waiting parks in
    // DROP until the orphaned reply has been absorbed.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_req_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_req_addr <= PCIn;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (MemAck)
                        r_state <= S_IDLE;
                    else if (Flush)
                        r_state <= S_DROP;
                end
                S_DROP: begin
                    if (MemAck)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Occupancy and pointers; flush empties the queue by snapping head to tail.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (Flush) begin
            r_count <= '0;
            r_head  <= r_tail;
        end else begin
            if (w_push)
                r_tail <= r_tail + PTR_W'(1);
            if (w_pop)
                r_head <= r_head + PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CNT_W'(1);
        end
    end

    // Entry storage; cleared on reset so the head reads as zero afterwards.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    r_instr_mem[gi] <= '0;
                    r_pc_mem[gi]    <= '0;
                end else if (w_push && (r_tail == PTR_W'(gi))) begin
                    r_instr_mem[gi] <= MemData;
                    r_pc_mem[gi]    <= r_req_addr;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer with a latency-programmable memory
// model, a next-PC model and a scoreboard of expected {PC, instruction}.
module tb_instr_fetch_buffer;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PCIn;
    logic        PCStall;
    logic        Flush;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemData;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;
    logic [31:0] InstrPCPlus4;

    instr_fetch_buffer #(.DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PCIn         (PCIn),
        .PCStall      (PCStall),
        .Flush        (Flush),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemAck       (MemAck),
        .MemData      (MemData),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .Instruction  (Instruction),
        .InstrPC      (InstrPC),
        .InstrPCPlus4 (InstrPCPlus4)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          pop_cnt = 0;
    int          lat     = 1;
    int          timer   = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] pc_next   = '0;
    logic [31:0] redirect  = '0;
    bit          stray_ack = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // First half of a cycle: drive the memory reply, then sample at negedge.
    task automatic half_a();
        exp_t e;
        if (stray_ack) begin
            MemAck    = 1'b1;
            MemData   = 32'hDEADBEEF;
            stray_ack = 1'b0;
        end else if (timer != 0) begin
            timer--;
            MemAck  = (timer == 0);
            MemData = (timer == 0) ? (pend_addr ^ KEY) : 32'h0;
        end else begin
            MemAck = 1'b0;
        end
        #4;
        if (InstrValid && InstrReady && !Flush) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pop_pc", InstrPC, e.pc);
                chk("pop_instr", Instruction, e.data);
                chk("pop_pc4", InstrPCPlus4, e.pc + 32'd4);
                $display("[TB] pop pc=%h instr=%h", InstrPC, Instruction);
            end
            pop_cnt++;
        end
        if (Flush) begin
            chk("no_req_in_flush", 32'(MemReq), 32'd0);
            sb.delete();
        end
        if (MemReq) begin
            chk("one_outstanding", timer, 0);
            chk("req_addr", MemAddr, PCIn);
            e.pc   = PCIn;
            e.data = PCIn ^ KEY;
            sb.push_back(e);
            pend_addr = MemAddr;
            timer     = lat;
            $display("[TB] req addr=%h", MemAddr);
        end
        if (Flush)         pc_next = redirect;
        else if (!PCStall) pc_next = PCIn + 32'd4;
        else               pc_next = PCIn;
    endtask

    task automatic half_b();
        @(posedge Clk);
        #1;
        PCIn = pc_next;
    endtask

    task automatic cycle();
        half_a();
        half_b();
    endtask

    task automatic do_reset(input logic [31:0] pc);
        Reset  = 1'b1;
        MemAck = 1'b0;
        Flush  = 1'b0;
        sb.delete();
        timer = 0;
        @(posedge Clk);
        #1;
        PCIn    = pc;
        pc_next = pc;
        Reset   = 1'b0;
    endtask

    task automatic run_pops(input int n, input int budget);
        int target;
        target = pop_cnt + n;
        for (int i = 0; i < budget; i++) begin
            if (pop_cnt >= target) break;
            cycle();
        end
        chk("pops_done", pop_cnt, target);
    endtask

    initial begin
        Reset = 1'b1; PCIn = '0; Flush = 1'b0; MemAck = 1'b0;
        MemData = '0; InstrReady = 1'b1;

        // Reset state
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_pc", InstrPC, 32'h0);
        chk("rst_pc4", InstrPCPlus4, 32'h4);
        chk("rst_memreq", 32'(MemReq), 32'd0);
        chk("rst_stall", 32'(PCStall), 32'd1);
        @(posedge Clk); #1;

        // 1: streaming with 1-cycle memory, requests every other cycle
        lat = 1; InstrReady = 1'b1;
        do_reset(32'h0);
        for (int i = 0; i < 6; i++) begin
            half_a();
            chk("t1_req_spacing", 32'(MemReq), 32'((i % 2) == 0));
            half_b();
        end
        run_pops(3, 20);

        // 2: decode stalled fills the FIFO, then drains
        lat = 1; InstrReady = 1'b0;
        do_reset(32'h0);
        for (int i = 0; i < 4; i++) cycle();
        for (int i = 0; i < 3; i++) begin
            half_a();
            chk("t2_memreq", 32'(MemReq), 32'd0);
            chk("t2_stall", 32'(PCStall), 32'd1);
            chk("t2_head_pc", InstrPC, 32'h0);
            half_b();
        end
        InstrReady = 1'b1;
        half_a();
        chk("t2_pop0", InstrPC, 32'h0);
        half_b();
        half_a();
        chk("t2_pop1", InstrPC, 32'h4);
        chk("t2_resume", 32'(MemReq), 32'd1);
        half_b();
        run_pops(2, 20);

        // 3: flush while waiting, late reply dropped
        lat = 3; InstrReady = 1'b1;
        do_reset(32'h0);
        cycle();
        Flush = 1'b1; redirect = 32'h40;
        half_a();
        chk("t3_valid_f", 32'(InstrValid), 32'd0);
        half_b();
        Flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            half_a();
            chk("t3_drop_req", 32'(MemReq), 32'd0);
            chk("t3_drop_valid", 32'(InstrValid), 32'd0);
            half_b();
        end
        half_a();
        chk("t3_valid_after", 32'(InstrValid), 32'd0);
        chk("t3_req", 32'(MemReq), 32'd1);
        chk("t3_addr", MemAddr, 32'h40);
        half_b();
        run_pops(2, 30);

        // 4: flush coincident with ack, one entry buffered
        lat = 1; InstrReady = 1'b0;
        do_reset(32'h0);
        for (int i = 0; i < 3; i++) cycle();
        Flush = 1'b1; redirect = 32'h80;
        half_a();
        chk("t4_valid_before", 32'(InstrValid), 32'd1);
        half_b();
        Flush = 1'b0;
        half_a();
        chk("t4_valid_after", 32'(InstrValid), 32'd0);
        chk("t4_req", 32'(MemReq), 32'd1);
        chk("t4_addr", MemAddr, 32'h80);
        half_b();
        InstrReady = 1'b1;
        run_pops(2, 20);

        // 5: push and pop together at count 1
        lat = 1; InstrReady = 1'b0;
        do_reset(32'h0);
        for (int i = 0; i < 3; i++) cycle();
        InstrReady = 1'b1;
        half_a();
        chk("t5_head0", InstrPC, 32'h0);
        half_b();
        half_a();
        chk("t5_valid", 32'(InstrValid), 32'd1);
        chk("t5_head1", InstrPC, 32'h4);
        chk("t5_req", 32'(MemReq), 32'd1);
        half_b();
        run_pops(2, 20);

        // 6a: PC+4 wraps at the top of the address space
        lat = 1; InstrReady = 1'b0;
        do_reset(32'hFFFFFFFC);
        cycle(); cycle();
        half_a();
        chk("t6_pc", InstrPC, 32'hFFFFFFFC);
        chk("t6_pc4_wrap", InstrPCPlus4, 32'h0);
        half_b();

        // 6b: async reset mid-WAIT, stray ack after release
        lat = 1; InstrReady = 1'b0;
        do_reset(32'h0);
        cycle(); cycle();
        lat = 3;
        cycle();
        #1 Reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(InstrValid), 32'd0);
        chk("t6_rst_instr", Instruction, 32'h0);
        chk("t6_rst_pc", InstrPC, 32'h0);
        chk("t6_rst_req", 32'(MemReq), 32'd0);
        chk("t6_rst_stall", 32'(PCStall), 32'd1);
        @(posedge Clk); #1;
        Reset = 1'b0;
        sb.delete();
        timer = 0; stray_ack = 1'b1; lat = 1;
        PCIn = 32'h100; pc_next = 32'h100; InstrReady = 1'b1;
        half_a();
        chk("t6_first_req", 32'(MemReq), 32'd1);
        chk("t6_first_addr", MemAddr, 32'h100);
        half_b();
        half_a();
        chk("t6_stray_ignored", 32'(InstrValid), 32'd0);
        half_b();
        half_a();
        chk("t6_real_valid", 32'(InstrValid), 32'd1);
        half_b();
        run_pops(1, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Instruction-fetch stage directly downstream of the program counter register.
- Takes the current PC value and issues one instruction-memory read at a time to a variable-latency memory.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Drives a stall back to the next-PC logic, and supports a flush for branch/jump redirects.

Parameters:
DEPTH, 2, FIFO entries (power of two, >= 2)
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width

Ports:
Clk  in  1  clock, all state updates on posedge
Reset  in  1  asynchronous, active-high reset
PCIn  in  ADDR_W  current PC (program counter PCResult)
PCStall  out  1  1 = next-PC logic must feed Address = PCIn (hold); 0 = PC may advance
Flush  in  1  redirect: discard buffered and in-flight instructions
MemReq  out  1  one-cycle read request pulse
MemAddr  out  ADDR_W  request address, valid with MemReq
MemAck  in  1  one-cycle pulse; MemData valid
MemData  in  DATA_W  returned instruction
InstrValid  out  1  head FIFO entry valid
InstrReady  in  1  decode accepts head entry
Instruction  out  DATA_W  head entry instruction
InstrPC  out  ADDR_W  head entry PC
InstrPCPlus4  out  ADDR_W  InstrPC + 4, modulo 2^ADDR_W

Behaviour:
Reset (async, Reset=1):
- State=IDLE; count, head and tail pointers = 0; ReqAddr = 0.
- InstrValid = 0, Instruction = 0, InstrPC = 0, InstrPCPlus4 = 4.
- MemReq forced 0 while Reset high; PCStall = 1.
- Reset mid-request: the outstanding request is forgotten; a later stray MemAck in IDLE is ignored.

FSM states: IDLE, WAIT, DROP.

IDLE:
- issue = (count < DEPTH) & ~Flush.
- On issue: MemReq = 1, MemAddr = PCIn, ReqAddr <= PCIn, go to WAIT.
- MemAck in IDLE is ignored.

WAIT:
- MemReq = 0.
- MemAck & ~Flush: push {MemData, ReqAddr} at tail, go to IDLE.
- MemAck & Flush: discard the data, go to IDLE.
- ~MemAck & Flush: go to DROP.
- Otherwise stay in WAIT.

DROP:
- MemReq = 0. On MemAck: discard the data, go to IDLE. Flush in DROP has no extra effect.

Combinational outputs:
- PCStall = ~issue. The PC advances exactly on the cycle a request is issued.
- During Flush the next-PC logic loads the redirect target regardless of PCStall.

Timing and throughput:
- MemAck arrives no earlier than the cycle after MemReq; there is at most one request outstanding.
- Minimum issue spacing is 2 cycles.
- An instruction is visible on InstrValid the cycle after its MemAck.

FIFO:
- count in 0..DEPTH; InstrValid = (count != 0).
- Instruction, InstrPC and InstrPCPlus4 come from the head entry and stay stable while InstrValid & ~InstrReady.
- pop = InstrValid & InstrReady & ~Flush.
- push and pop in the same cycle: count unchanged, both pointers advance.
- Overflow is impossible because an issue requires count < DEPTH with nothing outstanding. Pop when empty is a no-op.
- Pointers wrap modulo DEPTH.

Flush:
- Takes priority over push and pop.
- Same edge: count <= 0, head <= tail, InstrValid low the next cycle.
- No request is issued in the Flush cycle.
- Issue resumes from the new PCIn the cycle after Flush deasserts (IDLE) or after the dropped MemAck (DROP).

InstrPCPlus4 wraps: 0xFFFFFFFC + 4 = 0x00000000.

Test Plan:
1. Reset, PCIn=0x00000000, memory acks 1 cycle after each request with data=addr^0xA5A5A5A5, InstrReady=1 -> MemReq pulses every 2nd cycle; the PC sequence 0,4,8 emerges in order with Instruction=0xA5A5A5A5, 0xA5A5A5A1, 0xA5A5A5AD.
2. InstrReady=0, DEPTH=2 -> after 2 pushes count=2, MemReq stays 0, PCStall=1, the head holds PC 0x0. Raise InstrReady -> one pop per cycle and issue resumes.
3. Flush asserted while in WAIT (ack 3 cycles later) -> state goes to DROP, the late MemAck data is never presented (InstrValid stays 0), and the next MemAddr equals the redirect PC 0x00000040.
4. Flush in the same cycle as MemAck, with 1 entry buffered -> both the entry and the returned data are discarded; InstrValid=0 the next cycle.
5. Simultaneous push and pop with count=1 -> count stays 1 and the entries emerge in FIFO order.
6. Reset asserted asynchronously mid-WAIT, then a MemAck after release -> outputs clear immediately, the stray ack is ignored, and the first issue after release uses PCIn. Separately, InstrPC=0xFFFFFFFC gives InstrPCPlus4=0x00000000.
